alu_shift_pipe: RTL and testbench

Parametrised, pipelined shift/rotate execution unit: the successor to the single-cycle ALU shifter, adding rotates, rotate-through-carry, selectable latency, a per-flag write mask, stall and flush. It sits in an ALU lane after the reservation-station read. It accepts one operation per cycle and returns result, COASZP flags, flag-write mask and tag after STAGES cycles.

---
 rtl/alu_shift_pipe.sv | 205 ++++++++++++++++++++
 tb/tb_alu_shift_pipe.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_shift_pipe.sv
// alu_shift_pipe: pipelined shift/rotate execution unit.
// All computation happens in front of the first register. The remaining
// stages only delay the result, so STAGES sets the latency without
// changing the datapath. Stall freezes every stage, and flush clears
// every valid bit. Flush takes priority over stall.
module alu_shift_pipe #(
   parameter int WIDTH  = 64,
   parameter int STAGES = 2,
   parameter int TAG_W  = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_en,
   input  logic [2:0]       in_op,
   input  logic [1:0]       in_sz,
   input  logic [WIDTH-1:0] in_val,
   input  logic [7:0]       in_cnt,
   input  logic             in_cin,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             stall,
   input  logic             flush,
   output logic             out_en,
   output logic [WIDTH-1:0] out_val,
   output logic [5:0]       out_flags,
   output logic [5:0]       out_fl_we,
   output logic [TAG_W-1:0] out_tag
);
   localparam int IW = $clog2(WIDTH);
   localparam int PW = TAG_W + 12 + WIDTH;

   localparam logic [2:0] OP_SHL  = 3'd0;
   localparam logic [2:0] OP_SHR  = 3'd1;
   localparam logic [2:0] OP_SAR  = 3'd2;
   localparam logic [2:0] OP_ROL  = 3'd3;
   localparam logic [2:0] OP_ROR  = 3'd4;
   localparam logic [2:0] OP_RCL  = 3'd5;
   localparam logic [2:0] OP_RCR  = 3'd6;
   localparam logic [2:0] OP_PASS = 3'd7;

   localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

   // Operand size, masked count and the two rotate counts.
   logic [7:0]       size8;
   logic [7:0]       cnt8;
   logic [7:0]       rot8;
   logic [7:0]       rc8;
   logic [7:0]       m8;

   logic [WIDTH-1:0] size_mask;
   logic [WIDTH:0]   xmask;
   logic [WIDTH-1:0] opnd;
   logic [WIDTH-1:0] sext;
   logic [WIDTH:0]   rc_src;
   logic [IW-1:0]    msb_idx;
   logic [IW-1:0]    msb1_idx;
   logic [IW:0]      top_idx;

   logic [WIDTH-1:0] shl_res, shr_res, sar_res, rol_res, ror_res;
   logic             shl_c, shr_c, sar_c;
   logic [WIDTH:0]   rcl_x, rcr_x;

   logic [WIDTH-1:0] res;
   logic             c_flag;
   logic             o_flag;
   logic             rotate;
   logic [WIDTH-1:0] calc_val;
   logic [5:0]       calc_flags;
   logic [5:0]       calc_we;
   logic [PW-1:0]    calc_pl;

   // Count bits above 5 never take part in masking.
   logic             unused_cnt_hi;
   assign unused_cnt_hi = ^in_cnt[7:6];

   // Decode the operand size and derive the effective counts.
   always_comb begin
      case (in_sz)
         2'd0:    size8 = 8'd8;
         2'd1:    size8 = 8'd16;
         2'd2:    size8 = 8'd32;
         default: size8 = (WIDTH == 64) ? 8'd64 : 8'd32;
      endcase
      cnt8 = (size8 == 8'd64) ? {2'b00, in_cnt[5:0]} : {3'b000, in_cnt[4:0]};
      rot8 = cnt8 & (size8 - 8'd1);
      case (size8)
         8'd8:    rc8 = cnt8 % 8'd9;
         8'd16:   rc8 = cnt8 % 8'd17;
         default: rc8 = cnt8;
      endcase
      m8 = size8 + 8'd1;
   end

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
      assign size_mask[gi] = (8'(gi) < size8);
   end
   for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_xmask
      assign xmask[gi] = (8'(gi) <= size8);
   end

   assign msb_idx  = IW'(size8 - 8'd1);
   assign msb1_idx = IW'(size8 - 8'd2);
   assign top_idx  = (IW+1)'(size8);
   assign opnd     = in_val & size_mask;
   assign sext     = opnd[msb_idx] ? (opnd | ~size_mask) : opnd;
   assign rc_src   = {1'b0, opnd} | ((WIDTH+1)'(in_cin) << size8);

   // Candidate results for every operation. The carry comes from the bit
   // that the last step moved past the operand boundary. A count beyond
   // the size wraps the 8-bit shift amount, so the carry becomes 0.
   always_comb begin
      shl_res = (opnd << cnt8) & size_mask;
      shl_c   = |(opnd & (ONE_W << (size8 - cnt8)));
      shr_res = opnd >> cnt8;
      shr_c   = |(opnd & (ONE_W << (cnt8 - 8'd1)));
      sar_res = WIDTH'($signed(sext) >>> cnt8) & size_mask;
      sar_c   = |(sext & (ONE_W << (cnt8 - 8'd1)));
      rol_res = ((opnd << rot8) | (opnd >> (size8 - rot8))) & size_mask;
      ror_res = ((opnd >> rot8) | (opnd << (size8 - rot8))) & size_mask;
      rcl_x   = ((rc_src << rc8) | (rc_src >> (m8 - rc8))) & xmask;
      rcr_x   = ((rc_src >> rc8) | (rc_src << (m8 - rc8))) & xmask;
   end

   // Select the result and build the flags and the write mask.
   always_comb begin
      res    = opnd;
      c_flag = 1'b0;
      rotate = 1'b0;
      case (in_op)
         OP_SHL: begin res = shl_res; c_flag = shl_c; end
         OP_SHR: begin res = shr_res; c_flag = shr_c; end
         OP_SAR: begin res = sar_res; c_flag = sar_c; end
         OP_ROL: begin res = rol_res; c_flag = rol_res[0]; rotate = 1'b1; end
         OP_ROR: begin res = ror_res; c_flag = ror_res[msb_idx]; rotate = 1'b1; end
         OP_RCL: begin
            res    = rcl_x[WIDTH-1:0] & size_mask;
            c_flag = rcl_x[top_idx];
            rotate = 1'b1;
         end
         OP_RCR: begin
            res    = rcr_x[WIDTH-1:0] & size_mask;
            c_flag = rcr_x[top_idx];
            rotate = 1'b1;
         end
         default: res = opnd;
      endcase

      case (in_op)
         OP_SHL, OP_ROL, OP_RCL: o_flag = res[msb_idx] ^ c_flag;
         OP_SHR:                 o_flag = opnd[msb_idx];
         OP_ROR, OP_RCR:         o_flag = res[msb_idx] ^ res[msb1_idx];
         default:                o_flag = 1'b0;
      endcase
      if (cnt8 != 8'd1) o_flag = 1'b0;

      calc_val = res;
      if (in_op == OP_PASS || cnt8 == 8'd0) begin
         calc_val   = opnd;
         calc_flags = 6'b000000;
         calc_we    = 6'b000000;
      end else if (rotate) begin
         calc_flags = {c_flag, o_flag, 4'b0000};
         calc_we    = 6'b110000;
      end else begin
         calc_flags = {c_flag, o_flag, 1'b0, res[msb_idx], ~|res, ~^res[7:0]};
         calc_we    = 6'b111111;
      end
   end

   assign calc_pl = {in_tag, calc_we, calc_flags, calc_val};

   // Pipeline stages. Stage 0 captures the computed result, and later
   // stages copy from the stage before them.
   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      logic          v_reg;
      logic [PW-1:0] pl_reg;
      logic          src_v;
      logic [PW-1:0] src_pl;

      if (gi == 0) begin : g_head
         assign src_v  = in_en;
         assign src_pl = calc_pl;
      end else begin : g_link
         assign src_v  = g_stage[gi-1].v_reg;
         assign src_pl = g_stage[gi-1].pl_reg;
      end

      // Advance when not stalled. Payload loads only with valid data, so
      // the outputs stay 0 after reset until the first real result.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            v_reg  <= 1'b0;
            pl_reg <= '0;
         end else if (flush) begin
            v_reg <= 1'b0;
         end else if (!stall) begin
            v_reg <= src_v;
            if (src_v) pl_reg <= src_pl;
         end
      end
   end

   assign out_en = g_stage[STAGES-1].v_reg;
   assign {out_tag, out_fl_we, out_flags, out_val} = g_stage[STAGES-1].pl_reg;

endmodule

// File: tb/tb_alu_shift_pipe.sv
// Testbench for alu_shift_pipe. Three instances with STAGES = 1, 2 and 3
// share the same stimulus. Results are checked in order against a
// bit-serial reference model through a shared expectation table, with a
// separate read pointer for each instance.
module tb_alu_shift_pipe;
   localparam int SB_N = 4096;

   typedef struct packed {
      logic [63:0] val;
      logic [5:0]  flags;
      logic [5:0]  we;
      logic [8:0]  tag;
   } res_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_en;
   logic [2:0]  in_op;
   logic [1:0]  in_sz;
   logic [63:0] in_val;
   logic [7:0]  in_cnt;
   logic        in_cin;
   logic [8:0]  in_tag;
   logic        stall;
   logic        flush;

   logic        out_en    [3];
   logic [63:0] out_val   [3];
   logic [5:0]  out_flags [3];
   logic [5:0]  out_fl_we [3];
   logic [8:0]  out_tag   [3];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int stall_cnt = 0;
   int wr       = 0;
   int rd [3]   = '{0, 0, 0};
   logic [8:0] next_tag = 9'd0;

   res_t sb_exp [SB_N];
   int   sb_cyc [SB_N];
   int   sb_stl [SB_N];
   bit   sb_lit [SB_N];
   res_t sb_lv  [SB_N];

   bit   cur_lit = 1'b0;
   res_t cur_lv;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      alu_shift_pipe #(.WIDTH(64), .STAGES(gi + 1), .TAG_W(9)) u_dut (
         .clk(clk), .rst(rst), .in_en(in_en), .in_op(in_op), .in_sz(in_sz),
         .in_val(in_val), .in_cnt(in_cnt), .in_cin(in_cin), .in_tag(in_tag),
         .stall(stall), .flush(flush), .out_en(out_en[gi]),
         .out_val(out_val[gi]), .out_flags(out_flags[gi]),
         .out_fl_we(out_fl_we[gi]), .out_tag(out_tag[gi])
      );
   end

   task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
      end
   endtask

   // Reference model: perform the operation one bit per step, the way the
   // instruction is defined.
   function automatic res_t ref_model(input logic [2:0] op, input logic [1:0] sz,
                                      input logic [63:0] val, input logic [7:0] cnt,
                                      input logic cin, input logic [8:0] tag);
      res_t r;
      int n, k, steps;
      logic [63:0] mask, v;
      logic c, o, top, nb, msb0;
      n    = 8 << int'(sz);
      mask = (n == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
      k    = (n == 64) ? int'(cnt[5:0]) : int'(cnt[4:0]);
      v    = val & mask;
      msb0 = v[n-1];
      c    = 1'b0;
      o    = 1'b0;
      r.tag = tag;
      if (op == 3'd7 || k == 0) begin
         r.val = v; r.flags = 6'd0; r.we = 6'd0;
         return r;
      end
      case (op)
         3'd0: for (int i = 0; i < k; i++) begin c = v[n-1]; v = (v << 1) & mask; end
         3'd1: for (int i = 0; i < k; i++) begin c = v[0]; v = v >> 1; end
         3'd2: begin
            top = v[n-1];
            for (int i = 0; i < k; i++) begin
               c = v[0];
               v = (v >> 1) | ({63'd0, top} << (n - 1));
            end
         end
         3'd3: begin
            steps = k % n;
            for (int i = 0; i < steps; i++) begin top = v[n-1]; v = ((v << 1) | {63'd0, top}) & mask; end
            c = v[0];
         end
         3'd4: begin
            steps = k % n;
            for (int i = 0; i < steps; i++) begin nb = v[0]; v = (v >> 1) | ({63'd0, nb} << (n - 1)); end
            c = v[n-1];
         end
         3'd5: begin
            steps = k % (n + 1);
            c = cin;
            for (int i = 0; i < steps; i++) begin top = v[n-1]; v = ((v << 1) | {63'd0, c}) & mask; c = top; end
         end
         default: begin
            steps = k % (n + 1);
            c = cin;
            for (int i = 0; i < steps; i++) begin nb = v[0]; v = (v >> 1) | ({63'd0, c} << (n - 1)); c = nb; end
         end
      endcase
      if (k == 1) begin
         case (op)
            3'd0, 3'd3, 3'd5: o = v[n-1] ^ c;
            3'd1:             o = msb0;
            3'd4, 3'd6:       o = v[n-1] ^ v[n-2];
            default:          o = 1'b0;
         endcase
      end
      r.val = v;
      if (op >= 3'd3) begin
         r.flags = {c, o, 4'b0000};
         r.we    = 6'b110000;
      end else begin
         r.flags = {c, o, 1'b0, v[n-1], (v == 64'd0), ~^v[7:0]};
         r.we    = 6'b111111;
      end
      return r;
   endfunction

   // Scoreboard: consume results, check that stalled outputs hold, apply
   // flush and reset kills, and record accepted operations.
   logic [63:0] p_val [3];
   logic [21:0] p_ctl [3];
   bit          prev_hold = 1'b0;

   always @(negedge clk) begin : mon
      res_t e;
      int   idx;
      if (rst) begin
         for (int d = 0; d < 3; d++) rd[d] = wr;
         prev_hold = 1'b0;
      end else begin
         for (int d = 0; d < 3; d++) begin
            if (prev_hold) begin
               check_val($sformatf("hold_val_s%0d", d + 1), out_val[d], p_val[d]);
               check_val($sformatf("hold_ctl_s%0d", d + 1),
                         {out_en[d], out_tag[d], out_flags[d], out_fl_we[d]}, p_ctl[d]);
            end
            if (out_en[d] && !stall) begin
               if (rd[d] == wr) begin
                  check_val($sformatf("spurious_out_en_s%0d", d + 1), 64'(out_en[d]), 64'd0);
               end else begin
                  idx = rd[d] % SB_N;
                  e   = sb_exp[idx];
                  check_val($sformatf("tag_s%0d", d + 1), out_tag[d], e.tag);
                  check_val($sformatf("val_s%0d_t%0d", d + 1, e.tag), out_val[d], e.val);
                  check_val($sformatf("we_s%0d_t%0d", d + 1, e.tag), out_fl_we[d], e.we);
                  if (e.we != 6'd0)
                     check_val($sformatf("flags_s%0d_t%0d", d + 1, e.tag), out_flags[d], e.flags);
                  if (sb_lit[idx]) begin
                     check_val($sformatf("lit_val_s%0d", d + 1), out_val[d], sb_lv[idx].val);
                     check_val($sformatf("lit_we_s%0d", d + 1), out_fl_we[d], sb_lv[idx].we);
                     if (sb_lv[idx].we != 6'd0)
                        check_val($sformatf("lit_flags_s%0d", d + 1), out_flags[d], sb_lv[idx].flags);
                  end
                  if (sb_stl[idx] == stall_cnt)
                     check_val($sformatf("latency_s%0d", d + 1), 64'(cyc - sb_cyc[idx]), 64'(d + 1));
                  rd[d] = rd[d] + 1;
               end
            end
            p_val[d] = out_val[d];
            p_ctl[d] = {out_en[d], out_tag[d], out_flags[d], out_fl_we[d]};
         end
         if (flush) begin
            for (int d = 0; d < 3; d++) rd[d] = wr;
         end else if (!stall && in_en) begin
            idx         = wr % SB_N;
            sb_exp[idx] = ref_model(in_op, in_sz, in_val, in_cnt, in_cin, in_tag);
            sb_cyc[idx] = cyc;
            sb_stl[idx] = stall_cnt;
            sb_lit[idx] = cur_lit;
            sb_lv[idx]  = cur_lv;
            $display("txn tag=%0d op=%0d sz=%0d val=%h cnt=%0d cin=%0d exp_val=%h exp_flags=%b exp_we=%b",
                     in_tag, in_op, in_sz, in_val, in_cnt, in_cin,
                     sb_exp[idx].val, sb_exp[idx].flags, sb_exp[idx].we);
            wr = wr + 1;
         end
         if (stall) stall_cnt = stall_cnt + 1;
         prev_hold = stall && !flush;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic [2:0] op, input logic [1:0] sz, input logic [63:0] val,
                         input logic [7:0] cnt, input logic cin);
      in_en  = 1'b1;
      in_op  = op;
      in_sz  = sz;
      in_val = val;
      in_cnt = cnt;
      in_cin = cin;
      in_tag = next_tag;
      next_tag = next_tag + 9'd1;
   endtask

   task automatic send_lit(input logic [2:0] op, input logic [1:0] sz, input logic [63:0] val,
                           input logic [7:0] cnt, input logic cin, input logic [63:0] lval,
                           input logic [5:0] lfl, input logic [5:0] lwe);
      set_op(op, sz, val, cnt, cin);
      cur_lit      = 1'b1;
      cur_lv.val   = lval;
      cur_lv.flags = lfl;
      cur_lv.we    = lwe;
      cur_lv.tag   = 9'd0;
      step();
      cur_lit = 1'b0;
      in_en   = 1'b0;
   endtask

   task automatic send_rand();
      set_op(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), {$urandom, $urandom},
             8'($urandom), 1'($urandom));
      step();
      in_en = 1'b0;
   endtask

   task automatic check_zero(input string name);
      for (int d = 0; d < 3; d++) begin
         check_val($sformatf("%s_en_s%0d", name, d + 1), 64'(out_en[d]), 64'd0);
         check_val($sformatf("%s_val_s%0d", name, d + 1), out_val[d], 64'd0);
         check_val($sformatf("%s_ctl_s%0d", name, d + 1),
                   {out_flags[d], out_fl_we[d], out_tag[d]}, 64'd0);
      end
   endtask

   initial begin
      rst = 1'b1; in_en = 1'b0; in_op = 3'd0; in_sz = 2'd0; in_val = 64'd0;
      in_cnt = 8'd0; in_cin = 1'b0; in_tag = 9'd0; stall = 1'b0; flush = 1'b0;
      cur_lv = '0;
      repeat (3) @(posedge clk);
      #1;
      check_zero("in_reset");
      rst = 1'b0;
      step();
      step();
      check_zero("after_reset");

      // Directed vectors, sent back to back.
      send_lit(3'd0, 2'd2, 64'h8000_0001, 8'd1,    1'b0, 64'h2,    6'b110000, 6'b111111);
      send_lit(3'd2, 2'd0, 64'h80,        8'd3,    1'b0, 64'hF0,   6'b000101, 6'b111111);
      send_lit(3'd6, 2'd0, 64'h01,        8'd1,    1'b0, 64'h00,   6'b100000, 6'b110000);
      send_lit(3'd5, 2'd0, 64'h5A,        8'd9,    1'b1, 64'h5A,   6'b100000, 6'b110000);
      send_lit(3'd0, 2'd2, 64'h1234,      8'h40,   1'b0, 64'h1234, 6'b000000, 6'b000000);
      send_lit(3'd3, 2'd0, 64'h81,        8'd9,    1'b0, 64'h03,   6'b100000, 6'b110000);
      send_lit(3'd7, 2'd0, 64'hFFFF_1234, 8'd5,    1'b0, 64'h34,   6'b000000, 6'b000000);
      send_lit(3'd2, 2'd3, 64'h8000_0000_0000_0000, 8'd63, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFF, 6'b000101, 6'b111111);
      repeat (5) step();

      // Four back-to-back ops with a two-cycle stall in the middle.
      send_rand();
      send_rand();
      set_op(3'd0, 2'd0, 64'h1, 8'd1, 1'b0);
      stall = 1'b1;
      step();
      step();
      stall = 1'b0;
      in_en = 1'b0;
      send_rand();
      send_rand();
      repeat (5) step();

      // Flush with two ops in flight and a third presented in the flush cycle.
      send_rand();
      send_rand();
      set_op(3'd1, 2'd1, 64'hABCD, 8'd2, 1'b0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      in_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         for (int d = 0; d < 3; d++)
            check_val($sformatf("post_flush_en_s%0d_c%0d", d + 1, i), 64'(out_en[d]), 64'd0);
         step();
      end

      // Asynchronous reset in the middle of a stream.
      send_rand();
      send_rand();
      send_rand();
      set_op(3'd0, 2'd3, 64'hFFFF, 8'd4, 1'b0);
      #2 rst = 1'b1;
      #1 check_zero("mid_reset");
      @(posedge clk);
      #1;
      rst   = 1'b0;
      in_en = 1'b0;
      step();

      // Randomized traffic with occasional stall and flush.
      for (int i = 0; i < 500; i++) begin
         set_op(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), {$urandom, $urandom},
                8'd0, 1'($urandom));
         case ($urandom_range(0, 3))
            0:       in_cnt = 8'($urandom_range(0, 2));
            1:       in_cnt = 8'($urandom_range(7, 10));
            default: in_cnt = 8'($urandom);
         endcase
         in_en = ($urandom_range(0, 9) < 7);
         stall = ($urandom_range(0, 9) == 0);
         flush = ($urandom_range(0, 29) == 0);
         step();
      end
      in_en = 1'b0;
      stall = 1'b0;
      flush = 1'b0;
      repeat (6) step();
      for (int d = 0; d < 3; d++)
         check_val($sformatf("drain_s%0d", d + 1), 64'(rd[d]), 64'(wr));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
